lvds_tx_link: RTL and testbench
===============================

# lvds_tx_link

Parametrised LVDS transmit link controller between core logic and the vendor LVDS serializer. It generalises the fixed 9-channel × 10-bit transmitter to CHANNELS × WIDTH. It adds PLL reset/lock supervision, a training-pattern phase, a valid/ready data handshake and idle fill. It runs in the serializer core-clock domain and drives the serializer's flat parallel input bus and PLL reset.

## Interface
- CHANNELS, 9, number of serial lanes.
- WIDTH, 10, serialization factor (bits per lane per core cycle).
- TRAIN_CYCLES, 256, core cycles of training pattern per training phase (≥1).
- LOCK_TIMEOUT, 4096, cycles to wait for PLL lock before re-resetting the PLL (≥1).
- PLL_RST_CYCLES, 8, cycles O_pll_areset is held high per reset attempt (≥1).
- TRAIN_PATTERN, 10'h3E0, WIDTH-bit word sent on every lane during training.
- IDLE_PATTERN, 10'h27C, WIDTH-bit word sent on every lane when no data is accepted.

Ports:
- I_clk  in  1  core clock (serializer tx_coreclock).
- I_rst  in  1  asynchronous, active-high reset.
- I_tx_locked  in  1  PLL lock from serializer; asynchronous, synchronised internally.
- I_data  in  CHANNELS*WIDTH  payload; lane c = bits [c*WIDTH+WIDTH-1 : c*WIDTH], lane 0 in the LSBs.
- I_valid  in  1  payload valid.
- O_ready  out  1  payload accepted when I_valid && O_ready.
- I_retrain  in  1  single-cycle request to re-run training.
- O_tx_in  out  CHANNELS*WIDTH  registered word to serializer tx_in.
- O_pll_areset  out  1  serializer PLL reset.
- O_trained  out  1  high while in RUN.
- O_state  out  2  current state encoding, for debug.

## Operation
- Lock path: I_tx_locked passes through a 2-flop synchroniser to give lock_s. All decisions use lock_s.
- States and encodings:
  - PLL_RST = 0: O_pll_areset = 1. The counter runs PLL_RST_CYCLES, then the state moves to WAIT_LOCK.
  - WAIT_LOCK = 1: O_pll_areset = 0.
    - lock_s = 1 moves to TRAIN.
    - LOCK_TIMEOUT cycles without lock moves to PLL_RST.
  - TRAIN = 2: O_tx_in = TRAIN_PATTERN replicated on all lanes. After TRAIN_CYCLES words the state moves to RUN.
  - RUN = 3: O_ready = 1.
    - A transfer loads I_data into O_tx_in.
    - A cycle without a transfer loads IDLE_PATTERN on all lanes.
- Lock loss: lock_s = 0 in TRAIN or RUN moves to PLL_RST on the next cycle. This has priority over every other transition.
- I_retrain:
  - Honoured only in RUN; it moves the state to TRAIN and resets the training count.
  - Ignored in all other states.
  - A transfer in the same cycle is still accepted and emitted.
- One shared down-counter serves all three timed phases. It is reloaded on every state entry and is $clog2(max(TRAIN_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES)+1) bits wide.
- In PLL_RST and WAIT_LOCK, O_tx_in carries IDLE_PATTERN on all lanes.
- No data buffering. I_data is never dropped, because O_ready is low outside RUN.

## Timing
- Reset values:
  - state = PLL_RST, counter = PLL_RST_CYCLES.
  - O_pll_areset = 1, O_ready = 0, O_trained = 0, O_state = 0.
  - O_tx_in = IDLE_PATTERN replicated on all lanes.
  - Synchroniser flops = 0.
- O_ready, O_trained, O_pll_areset and O_state decode the state register only; there is no combinational input-to-output path.
- Data latency: a transfer at edge t appears on O_tx_in after edge t+1, i.e. 1 cycle.
- Lock latency: an I_tx_locked change is seen by the FSM 2 cycles later. The state changes on the following edge.
- PLL_RST lasts exactly PLL_RST_CYCLES cycles.
- TRAIN emits exactly TRAIN_CYCLES pattern words. The first data or idle word follows immediately, with no gap.
- Retrain with transfer at cycle t: data word at t+1, then TRAIN_CYCLES training words from t+2.
- Lock lost in RUN at cycle t (lock_s):
  - O_ready = 0 from t+1.
  - O_tx_in becomes idle from t+2; the word accepted at t is still emitted at t+1.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronously).

## Structure
- Package lvds_tx_pkg holds:
  - the state typedef (PLL_RST, WAIT_LOCK, TRAIN, RUN) with the fixed encodings above;
  - default TRAIN_PATTERN and IDLE_PATTERN constants.
- One sub-module, lvds_lock_sync: a 2-flop synchroniser with async active-high reset to 0.
- The vendor serializer is instantiated outside this block. O_tx_in connects directly to its tx_in, and O_pll_areset to its pll_areset.

## Test plan
- Reset, lock rising 20 cycles after O_pll_areset falls:
  - O_pll_areset high for 8 cycles;
  - 256 words of 10'h3E0 on all 9 lanes;
  - then 10'h27C, O_trained = 1, O_state = 3.
- Lock held low: O_pll_areset re-pulses for 8 cycles every 8+4096 cycles; O_ready never rises.
- In RUN, stream I_data = lane c carries c+1, with I_valid toggling every cycle: O_tx_in alternates data and idle, each 1 cycle after acceptance.
- I_retrain with I_valid in the same cycle, data 10'h155 on all lanes: one 10'h155 word, then exactly 256 training words, then RUN.
- Drop I_tx_locked in RUN with I_valid held: O_ready falls 3 cycles after the drop, the last accepted word is still emitted, and the state goes to PLL_RST.
- CHANNELS=4, WIDTH=8, TRAIN_CYCLES=1: lane packing is correct, the single training word is emitted, and widths elaborate cleanly.

Source files
------------

// File: rtl/lvds_tx_pkg.sv
// -----------------------------------------------------------------------------
// lvds_tx_pkg
// Shared types and constants for the LVDS transmit link controller.
//   tx_state_t        : link FSM states. The encodings are visible on O_state.
//   DEF_TRAIN_PATTERN : default per-lane training word (10-bit).
//   DEF_IDLE_PATTERN  : default per-lane idle fill word (10-bit).
//   max3()            : helper used to size the shared phase counter.
// -----------------------------------------------------------------------------
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        TRAIN     = 2'd2,
        RUN       = 2'd3
    } tx_state_t;

    localparam logic [9:0] DEF_TRAIN_PATTERN = 10'h3E0;
    localparam logic [9:0] DEF_IDLE_PATTERN  = 10'h27C;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lvds_lock_sync.sv
// -----------------------------------------------------------------------------
// lvds_lock_sync
// Two-flop synchroniser that brings the serializer PLL lock flag into the
// core-clock domain.
//   I_clk   : destination clock
//   I_rst   : asynchronous active-high reset, clears both flops
//   I_async : asynchronous input
//   O_sync  : synchronised output, 2 cycles of latency
// -----------------------------------------------------------------------------
module lvds_lock_sync (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_async,
    output logic O_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= I_async;
            r_sync <= r_meta;
        end
    end

    assign O_sync = r_sync;

endmodule

// File: rtl/lvds_tx_link.sv
// -----------------------------------------------------------------------------
// lvds_tx_link
// LVDS transmit link controller. It supervises the serializer PLL through a
// reset/lock sequence, sends a training pattern, and then passes payload words
// through a valid/ready handshake. Idle words fill the cycles with no payload.
//   I_clk        : serializer core clock
//   I_rst        : asynchronous active-high reset
//   I_tx_locked  : PLL lock, asynchronous (synchronised internally)
//   I_data       : payload, lane c at [c*WIDTH +: WIDTH]
//   I_valid      : payload valid
//   O_ready      : high in RUN; transfer = I_valid && O_ready
//   I_retrain    : request to re-run training (honoured only in RUN)
//   O_tx_in      : registered parallel word to the serializer tx_in
//   O_pll_areset : serializer PLL reset
//   O_trained    : high in RUN
//   O_state      : state encoding, for debug
// -----------------------------------------------------------------------------
module lvds_tx_link
    import lvds_tx_pkg::*;
#(
    parameter int               CHANNELS       = 9,
    parameter int               WIDTH          = 10,
    parameter int               TRAIN_CYCLES   = 256,
    parameter int               LOCK_TIMEOUT   = 4096,
    parameter int               PLL_RST_CYCLES = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN  = WIDTH'(DEF_TRAIN_PATTERN),
    parameter logic [WIDTH-1:0] IDLE_PATTERN   = WIDTH'(DEF_IDLE_PATTERN)
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_tx_locked,
    input  logic [CHANNELS*WIDTH-1:0] I_data,
    input  logic                      I_valid,
    output logic                      O_ready,
    input  logic                      I_retrain,
    output logic [CHANNELS*WIDTH-1:0] O_tx_in,
    output logic                      O_pll_areset,
    output logic                      O_trained,
    output logic [1:0]                O_state
);

    // One down-counter times all three phases, so it is sized for the longest.
    localparam int CNT_MAX = max3(TRAIN_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_PLL   = CW'(PLL_RST_CYCLES);
    localparam logic [CW-1:0] CNT_LOCK  = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] CNT_TRAIN = CW'(TRAIN_CYCLES);

    localparam logic [CHANNELS*WIDTH-1:0] TRAIN_WORD = {CHANNELS{TRAIN_PATTERN}};
    localparam logic [CHANNELS*WIDTH-1:0] IDLE_WORD  = {CHANNELS{IDLE_PATTERN}};

    tx_state_t                 r_state;
    tx_state_t                 w_state_next;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             w_cnt_next;
    logic [CHANNELS*WIDTH-1:0] r_tx;
    logic [CHANNELS*WIDTH-1:0] w_tx_next;
    logic                      w_lock_s;
    logic                      w_xfer;

    lvds_lock_sync u_lock_sync (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_async (I_tx_locked),
        .O_sync  (w_lock_s)
    );

    // Ready decodes only the state register, so the transfer term has no
    // combinational path from I_valid to any output.
    assign w_xfer = (r_state == RUN) && I_valid;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= PLL_RST;
            r_cnt   <= CNT_PLL;
            r_tx    <= IDLE_WORD;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tx    <= w_tx_next;
        end
    end

    // The output word depends on the current state, not the next one. On the
    // edge that leaves RUN (retrain or lock loss), the word accepted on that
    // edge is still emitted.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_tx_next    = IDLE_WORD;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = CNT_LOCK;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = TRAIN;
                    w_cnt_next   = CNT_TRAIN;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_next = PLL_RST;
                    w_cnt_next   = CNT_PLL;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                end
            end
            TRAIN: begin
                w_tx_next = TRAIN_WORD;
                if (!w_lock_s) begin
                    w_state_next = PLL_RST;
                    w_cnt_next   = CNT_PLL;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_next = RUN;
                    w_cnt_next   = CNT_TRAIN;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                end
            end
            RUN: begin
                w_tx_next = w_xfer ? I_data : IDLE_WORD;
                if (!w_lock_s) begin
                    w_state_next = PLL_RST;
                    w_cnt_next   = CNT_PLL;
                end else if (I_retrain) begin
                    w_state_next = TRAIN;
                    w_cnt_next   = CNT_TRAIN;
                end
            end
            default: begin
                w_state_next = PLL_RST;
                w_cnt_next   = CNT_PLL;
            end
        endcase
    end

    assign O_tx_in      = r_tx;
    assign O_ready      = (r_state == RUN);
    assign O_trained    = (r_state == RUN);
    assign O_pll_areset = (r_state == PLL_RST);
    assign O_state      = r_state;

endmodule

// File: tb/tb_lvds_tx_link.sv
// -----------------------------------------------------------------------------
// tb_lvds_tx_link
// Directed bench for lvds_tx_link. One instance uses the default 9x10
// configuration. A second instance uses a 4x8 configuration with a single
// training word. Inputs change and outputs are sampled on the falling clock
// edge.
// -----------------------------------------------------------------------------
module tb_lvds_tx_link;

    localparam int CH = 9;
    localparam int W  = 10;

    logic          clk;
    logic          rst, locked, valid, retrain;
    logic          ready, pll_areset, trained;
    logic [CH*W-1:0] data, tx;
    logic [1:0]    state;

    logic          s_rst, s_locked, s_valid, s_retrain;
    logic          s_ready, s_areset, s_trained;
    logic [31:0]   s_data, s_tx;
    logic [1:0]    s_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    lvds_tx_link #(
        .CHANNELS       (9),
        .WIDTH          (10),
        .TRAIN_CYCLES   (256),
        .LOCK_TIMEOUT   (4096),
        .PLL_RST_CYCLES (8),
        .TRAIN_PATTERN  (10'h3E0),
        .IDLE_PATTERN   (10'h27C)
    ) u_dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_tx_locked  (locked),
        .I_data       (data),
        .I_valid      (valid),
        .O_ready      (ready),
        .I_retrain    (retrain),
        .O_tx_in      (tx),
        .O_pll_areset (pll_areset),
        .O_trained    (trained),
        .O_state      (state)
    );

    lvds_tx_link #(
        .CHANNELS       (4),
        .WIDTH          (8),
        .TRAIN_CYCLES   (1),
        .LOCK_TIMEOUT   (16),
        .PLL_RST_CYCLES (2),
        .TRAIN_PATTERN  (8'hA5),
        .IDLE_PATTERN   (8'h3C)
    ) u_dut_small (
        .I_clk        (clk),
        .I_rst        (s_rst),
        .I_tx_locked  (s_locked),
        .I_data       (s_data),
        .I_valid      (s_valid),
        .O_ready      (s_ready),
        .I_retrain    (s_retrain),
        .O_tx_in      (s_tx),
        .O_pll_areset (s_areset),
        .O_trained    (s_trained),
        .O_state      (s_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [CH*W-1:0] rep10(input logic [9:0] w);
        logic [CH*W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*W +: W] = w;
        return r;
    endfunction

    // Lane c carries base + c + 1.
    function automatic logic [CH*W-1:0] lanes_seq(input int base);
        logic [CH*W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*W +: W] = 10'(base + c + 1);
        return r;
    endfunction

    logic [CH*W-1:0] train_w;
    logic [CH*W-1:0] idle_w;
    int              n;
    logic            seen_ready;

    initial begin
        train_w = rep10(10'h3E0);
        idle_w  = rep10(10'h27C);

        rst = 1'b1; locked = 1'b0; valid = 1'b0; retrain = 1'b0; data = '0;
        s_rst = 1'b1; s_locked = 1'b0; s_valid = 1'b0; s_retrain = 1'b0; s_data = '0;
        repeat (3) step();

        // Reset state
        chk_val("rst_areset",  96'(pll_areset), 96'(1));
        chk_val("rst_ready",   96'(ready),      96'(0));
        chk_val("rst_trained", 96'(trained),    96'(0));
        chk_val("rst_state",   96'(state),      96'(0));
        chk_val("rst_tx",      96'(tx),         96'(idle_w));
        chk_val("small_rst_tx", 96'(s_tx),      96'(32'h3C3C3C3C));

        // PLL reset pulse length after release
        rst = 1'b0;
        n = 0;
        while (pll_areset && n < 100) begin step(); n++; end
        chk_val("pll_rst_len", 96'(n), 96'(8));

        // Lock rises 20 cycles after the PLL reset falls
        repeat (20) step();
        chk_val("wait_lock_state", 96'(state), 96'(1));
        chk_val("wait_lock_ready", 96'(ready), 96'(0));
        locked = 1'b1;
        n = 0;
        while (state != 2'd2 && n < 50) begin step(); n++; end
        chk_val("lock_latency", 96'(n), 96'(3));

        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tx !== train_w) break;
            n++;
        end
        chk_val("train_words",    96'(n),       96'(256));
        chk_val("run_first_idle", 96'(tx),      96'(idle_w));
        chk_val("run_trained",    96'(trained), 96'(1));
        chk_val("run_state",      96'(state),   96'(3));
        chk_val("run_ready",      96'(ready),   96'(1));

        // Streaming with valid toggling every cycle
        for (int k = 0; k < 3; k++) begin
            data = lanes_seq(k * 16); valid = 1'b1;
            step();
            chk_val("stream_data", 96'(tx), 96'(lanes_seq(k * 16)));
            data = lanes_seq(500); valid = 1'b0;
            step();
            chk_val("stream_idle", 96'(tx), 96'(idle_w));
        end

        // Retrain together with a transfer
        data = rep10(10'h155); valid = 1'b1; retrain = 1'b1;
        step();
        chk_val("retrain_word",  96'(tx),    96'(rep10(10'h155)));
        chk_val("retrain_state", 96'(state), 96'(2));
        valid = 1'b0; retrain = 1'b0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tx !== train_w) break;
            n++;
        end
        chk_val("retrain_train_words", 96'(n),     96'(256));
        chk_val("retrain_end_idle",    96'(tx),    96'(idle_w));
        chk_val("retrain_end_state",   96'(state), 96'(3));

        // Lock lost in RUN with valid held high
        valid = 1'b1; data = lanes_seq(100); locked = 1'b0;
        step();
        chk_val("drop1_ready", 96'(ready), 96'(1));
        chk_val("drop1_tx",    96'(tx),    96'(lanes_seq(100)));
        data = lanes_seq(200);
        step();
        chk_val("drop2_ready", 96'(ready), 96'(1));
        chk_val("drop2_tx",    96'(tx),    96'(lanes_seq(200)));
        data = lanes_seq(300);
        step();
        chk_val("drop3_ready",   96'(ready),      96'(0));
        chk_val("drop3_last_tx", 96'(tx),         96'(lanes_seq(300)));
        chk_val("drop3_state",   96'(state),      96'(0));
        chk_val("drop3_areset",  96'(pll_areset), 96'(1));
        data = lanes_seq(400);

        // Lock held low: reset pulse, full timeout, reset pulse again
        seen_ready = 1'b0;
        n = 0;
        while (pll_areset && n < 100) begin
            if (ready) seen_ready = 1'b1;
            step(); n++;
        end
        chk_val("relock_rst_len", 96'(n),  96'(8));
        chk_val("relock_tx_idle", 96'(tx), 96'(idle_w));
        n = 0;
        while (!pll_areset && n < 5000) begin
            if (ready) seen_ready = 1'b1;
            step(); n++;
        end
        chk_val("lock_timeout_len", 96'(n), 96'(4096));
        n = 0;
        while (pll_areset && n < 100) begin
            if (ready) seen_ready = 1'b1;
            step(); n++;
        end
        chk_val("repulse_len", 96'(n),          96'(8));
        chk_val("ready_never", 96'(seen_ready), 96'(0));
        valid = 1'b0;

        // Small configuration: 4 lanes x 8 bits, one training word
        s_locked = 1'b1;
        step();
        s_rst = 1'b0;
        n = 0;
        while (s_state != 2'd2 && n < 50) begin step(); n++; end
        chk_val("small_reach_train", 96'(s_state), 96'(2));
        step();
        chk_val("small_train_word", 96'(s_tx),    96'(32'hA5A5A5A5));
        chk_val("small_run_state",  96'(s_state), 96'(3));
        s_data = 32'h44332211; s_valid = 1'b1;
        step();
        chk_val("small_pack", 96'(s_tx), 96'(32'h44332211));
        s_valid = 1'b0;
        step();
        chk_val("small_idle", 96'(s_tx), 96'(32'h3C3C3C3C));

        // Asynchronous reset while the clock is low
        #2 s_rst = 1'b1;
        #1;
        chk_val("async_rst_state",  96'(s_state),  96'(0));
        chk_val("async_rst_areset", 96'(s_areset), 96'(1));
        chk_val("async_rst_ready",  96'(s_ready),  96'(0));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
